// File: rtl/fetch_pkg.sv
// Shared constants and types for the instruction fetch front-end.
package fetch_pkg;

  localparam int IW_DEF = 16;
  localparam int AW_DEF = 4;

  localparam logic [3:0] OPC_ADD  = 4'h1;
  localparam logic [3:0] OPC_SUB  = 4'h2;
  localparam logic [3:0] OPC_AND  = 4'h3;
  localparam logic [3:0] OPC_LOAD = 4'h4;
  localparam logic [3:0] OPC_HALT = 4'hF;

  typedef struct packed {
    logic [IW_DEF-1:0] instr;
    logic [AW_DEF-1:0] pc;
  } fetch_entry_t;

  // True when an opcode field stops the fetch stream.
  function automatic logic is_halt(input logic [3:0] opc);
    return opc == OPC_HALT;
  endfunction

endpackage

// File: rtl/sync_fifo.sv
// First-word fall-through FIFO with synchronous flush and occupancy count.
module sync_fifo #(
  parameter  int WIDTH = 20,
  parameter  int DEPTH = 4,
  localparam int PW    = $clog2(DEPTH),
  localparam int CW    = PW + 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] head_data,
  output logic             empty,
  output logic [CW-1:0]    count
);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [PW-1:0]    r_wr_ptr;
  logic [PW-1:0]    r_rd_ptr;
  logic [CW-1:0]    r_count;
  logic             w_full;
  logic             w_push;
  logic             w_pop;

  assign empty  = (r_count == '0);
  assign w_full = (r_count == CW'(DEPTH));
  assign count  = r_count;
  // Flush wins over any concurrent push or pop.
  assign w_push = push & ~flush;
  assign w_pop  = pop & ~flush & ~empty;
  // Head is forced to zero when empty so stale storage never leaks out.
  assign head_data = empty ? '0 : r_mem[r_rd_ptr];

  // Storage array; contents only matter between the pointers, so no reset.
  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wr_ptr] <= push_data;
  end

  // Pointer and occupancy bookkeeping.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else if (flush) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + PW'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + PW'(1);
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  // Upstream credit logic must never push into a full FIFO.
  always_ff @(posedge clk) begin
    if (rst_n) assert (!(w_push && w_full));
  end

endmodule

// File: rtl/instr_prefetch_unit.sv
// Fetch front-end: program memory, PC, one-cycle read stage and prefetch FIFO.
module instr_prefetch_unit
  import fetch_pkg::*;
#(
  parameter  int IW    = IW_DEF,
  parameter  int AW    = AW_DEF,
  parameter  int DEPTH = 4,
  localparam int CW    = $clog2(DEPTH) + 1
) (
  input  logic          clk,
  input  logic          reset_n,
  input  logic          fetch_en,
  input  logic          prog_we,
  input  logic [AW-1:0] prog_addr,
  input  logic [IW-1:0] prog_data,
  input  logic          redirect_valid,
  input  logic [AW-1:0] redirect_pc,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [IW-1:0] out_instr,
  output logic [AW-1:0] out_pc,
  output logic          halted,
  output logic [CW-1:0] fifo_count
);

  logic [IW-1:0]    r_mem [2**AW];
  logic [AW-1:0]    r_fetch_pc;
  logic [IW-1:0]    r_rd_data;
  logic [AW-1:0]    r_rd_pc;
  logic             r_rd_vld;
  logic             r_halted;

  logic             w_halt_det;
  logic [CW:0]      w_credit;
  logic             w_issue;
  logic             w_push;
  logic             w_pop;
  logic             w_empty;
  logic [IW+AW-1:0] w_head;

  assign w_halt_det = r_rd_vld & is_halt(r_rd_data[IW-1 -: 4]);
  // Credit counts the word in the read stage too; the same-cycle pop is ignored.
  assign w_credit   = {1'b0, fifo_count} + (CW+1)'(r_rd_vld);
  assign w_issue    = fetch_en & ~r_halted & ~w_halt_det & ~redirect_valid &
                      (w_credit < (CW+1)'(DEPTH));
  assign w_push     = r_rd_vld;
  assign w_pop      = out_valid & out_ready;

  assign out_valid  = ~w_empty;
  assign out_instr  = w_head[IW+AW-1:AW];
  assign out_pc     = w_head[AW-1:0];
  assign halted     = r_halted;

  // Program memory write port; survives reset by design.
  always_ff @(posedge clk) begin
    if (prog_we) r_mem[prog_addr] <= prog_data;
  end

  // Read stage and PC: redirect overrides everything, else issue one word.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_fetch_pc <= '0;
      r_rd_data  <= '0;
      r_rd_pc    <= '0;
      r_rd_vld   <= 1'b0;
    end else if (redirect_valid) begin
      r_fetch_pc <= redirect_pc;
      r_rd_vld   <= 1'b0;
    end else if (w_issue) begin
      r_rd_data  <= r_mem[r_fetch_pc];
      r_rd_pc    <= r_fetch_pc;
      r_rd_vld   <= 1'b1;
      r_fetch_pc <= r_fetch_pc + AW'(1);
    end else begin
      r_rd_vld   <= 1'b0;
    end
  end

  // Halt latch: set when a HALT word leaves the read stage, cleared by redirect.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)            r_halted <= 1'b0;
    else if (redirect_valid) r_halted <= 1'b0;
    else if (w_halt_det)     r_halted <= 1'b1;
  end

  sync_fifo #(
    .WIDTH (IW + AW),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst_n     (reset_n),
    .flush     (redirect_valid),
    .push      (w_push),
    .push_data ({r_rd_data, r_rd_pc}),
    .pop       (w_pop),
    .head_data (w_head),
    .empty     (w_empty),
    .count     (fifo_count)
  );

endmodule

// File: tb/tb_instr_prefetch_unit.sv
// Scoreboard bench: expected fetch stream is derived from a program image model.
module tb_instr_prefetch_unit;
  import fetch_pkg::*;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        fetch_en, prog_we, redirect_valid, out_ready;
  logic [3:0]  prog_addr, redirect_pc;
  logic [15:0] prog_data;
  logic        out_valid, halted;
  logic [15:0] out_instr;
  logic [3:0]  out_pc;
  logic [2:0]  fifo_count;

  int errors = 0;
  int checks = 0;
  int pops   = 0;
  logic [15:0]  mm [16];
  fetch_entry_t q[$];

  instr_prefetch_unit dut (
    .clk(clk), .reset_n(reset_n), .fetch_en(fetch_en), .prog_we(prog_we),
    .prog_addr(prog_addr), .prog_data(prog_data), .redirect_valid(redirect_valid),
    .redirect_pc(redirect_pc), .out_valid(out_valid), .out_ready(out_ready),
    .out_instr(out_instr), .out_pc(out_pc), .halted(halted), .fifo_count(fifo_count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk); #1;
  endtask

  // Architectural expectation: consecutive words from start, wrapping, ending at HALT.
  task automatic gen_stream(input logic [3:0] start);
    logic [3:0] p = start;
    q.delete();
    for (int k = 0; k < 256; k++) begin
      q.push_back('{instr: mm[p], pc: p});
      if (mm[p][15:12] == 4'hF) break;
      p = p + 4'd1;
    end
  endtask

  task automatic wr(input logic [3:0] a, input logic [15:0] d);
    prog_we = 1'b1; prog_addr = a; prog_data = d;
    tick();
    prog_we = 1'b0;
    mm[a] = d;
  endtask

  task automatic redirect(input logic [3:0] pc);
    redirect_valid = 1'b1; redirect_pc = pc;
    q.delete();
    tick();
    redirect_valid = 1'b0;
    gen_stream(pc);
  endtask

  task automatic drain();
    fetch_en = 1'b0; out_ready = 1'b1;
    repeat (8) tick();
  endtask

  function automatic logic [15:0] rnd_word(input int halt_odds);
    logic [15:0] w = 16'($urandom);
    if (halt_odds > 0 && $urandom_range(0, halt_odds - 1) == 0) w[15:12] = 4'hF;
    else w[15:12] = 4'($urandom_range(0, 14));
    return w;
  endfunction

  // Monitor: every accepted handshake must match the head of the expected stream.
  always @(negedge clk) begin
    if (reset_n) begin
      checks++;
      if (fifo_count > 3'd4) begin
        errors++;
        $display("FAIL fifo_bound: got %0d expected <=4", fifo_count);
      end
      if (out_valid && out_ready && !redirect_valid) begin
        checks++;
        if (q.size() == 0) begin
          errors++;
          $display("FAIL unexpected_out: got pc=%0h instr=%0h expected none", out_pc, out_instr);
        end else begin
          fetch_entry_t e;
          e = q.pop_front();
          pops++;
          if (out_pc !== e.pc || out_instr !== e.instr) begin
            errors++;
            $display("FAIL stream: got pc=%0h instr=%0h expected pc=%0h instr=%0h",
                     out_pc, out_instr, e.pc, e.instr);
          end
        end
      end
    end
  end

  initial begin
    int p0;
    for (int i = 0; i < 16; i++) mm[i] = 16'h0;
    reset_n = 1'b0; fetch_en = 1'b0; prog_we = 1'b0; redirect_valid = 1'b0;
    out_ready = 1'b0; prog_addr = '0; prog_data = '0; redirect_pc = '0;
    #12;
    chk("rst_valid", out_valid, 0);
    chk("rst_count", fifo_count, 0);
    chk("rst_halted", halted, 0);
    chk("rst_instr", out_instr, 0);
    chk("rst_pc", out_pc, 0);
    tick();
    reset_n = 1'b1;

    // Directed program with HALT at pc 3; check first-valid latency.
    wr(4'd0, 16'h1234); wr(4'd1, 16'h2345); wr(4'd2, 16'h3456); wr(4'd3, 16'hF000);
    gen_stream(4'd0);
    fetch_en = 1'b1; out_ready = 1'b1;
    #2 chk("lat_c0", out_valid, 0);
    tick(); #2 chk("lat_c1", out_valid, 0);
    tick(); #2 chk("lat_c2", out_valid, 1);
    chk("lat_pc", out_pc, 0);
    repeat (12) tick();
    chk("halt_set", halted, 1);
    chk("halt_drained", q.size(), 0);
    chk("halt_no_more", out_valid, 0);

    // HALT-free image; FIFO saturates with decode stalled.
    for (int i = 0; i < 16; i++) wr(4'(i), rnd_word(0));
    out_ready = 1'b0; fetch_en = 1'b1;
    redirect(4'd0);
    repeat (10) tick();
    chk("sat_count", fifo_count, 4);
    out_ready = 1'b1;
    p0 = pops;
    repeat (12) tick();
    chk("sat_release_pops", (pops - p0 >= 10), 1);

    // PC wrap 14,15,0,1.
    drain();
    wr(4'd15, 16'h1111); wr(4'd0, 16'h2222);
    fetch_en = 1'b1;
    p0 = pops;
    redirect(4'd14);
    repeat (8) tick();
    chk("wrap_pops", (pops - p0 >= 4), 1);

    // Redirect with 3 queued entries and one in the read stage.
    out_ready = 1'b0;
    redirect(4'd2);
    repeat (4) tick();
    chk("pre_redir_count", fifo_count, 3);
    out_ready = 1'b1;
    redirect(4'd9);
    #2 chk("flush_count", fifo_count, 0);
    chk("flush_valid", out_valid, 0);
    tick(); #2 chk("redir_c1", out_valid, 0);
    tick(); #2 chk("redir_c2", out_valid, 1);
    chk("redir_pc", out_pc, 9);

    // Redirect out of the halted state.
    drain();
    wr(4'd5, 16'hF123);
    fetch_en = 1'b1;
    redirect(4'd3);
    repeat (12) tick();
    chk("halt2_set", halted, 1);
    chk("halt2_drained", q.size(), 0);
    redirect(4'd7);
    #2 chk("halt_clear", halted, 0);
    repeat (30) tick();
    chk("halt3_set", halted, 1);
    chk("halt3_drained", q.size(), 0);

    // Asynchronous reset mid-stream, then restart from pc 0 with image intact.
    out_ready = 1'b0;
    redirect(4'd0);
    repeat (6) tick();
    chk("pre_rst_valid", out_valid, 1);
    #2 reset_n = 1'b0;
    q.delete();
    #1;
    chk("arst_valid", out_valid, 0);
    chk("arst_count", fifo_count, 0);
    chk("arst_halted", halted, 0);
    tick(); tick();
    out_ready = 1'b1;
    reset_n = 1'b1;
    gen_stream(4'd0);
    repeat (16) tick();
    chk("post_rst_drained", q.size(), 0);
    chk("post_rst_halted", halted, 1);

    // Randomized traffic: random image with some HALTs, stalls and redirects.
    drain();
    for (int i = 0; i < 16; i++) wr(4'(i), rnd_word(6));
    fetch_en = 1'b1;
    redirect(4'($urandom_range(0, 15)));
    for (int it = 0; it < 500; it++) begin
      out_ready = ($urandom_range(0, 3) != 0);
      fetch_en  = ($urandom_range(0, 7) != 0);
      if ($urandom_range(0, 24) == 0) redirect(4'($urandom_range(0, 15)));
      else tick();
    end
    drain();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
